nibble_add_seq: RTL and testbench

//  Multi-cycle sequencer that adds or subtracts WIDTH-bit operands through one shared 4-bit ripple adder (FA4).
//  It processes one nibble per clock, LSB nibble first, and keeps the running carry in a flop between nibbles.

---
 rtl/nibble_add_seq.sv | 133 +++++++++++++
 tb/tb_nibble_add_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: multi-cycle adder/subtractor built around one shared 4-bit ripple adder.
// A command is accepted in IDLE. The operands are then processed one nibble per clock,
// LSB nibble first, and the running carry is held in a flop between nibbles. The result
// is held in DONE until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   command valid          in_ready   command accepted when high (IDLE)
//   a, b       WIDTH-bit operands     sub        1: a-b, 0: a+b+cin
//   cin        add carry-in (ignored for sub)
//   out_valid  result valid (DONE)    out_ready  consumer takes result
//   sum        WIDTH-bit result       cout       carry out of MSB (sub: 1 = no borrow)
//   ovf        signed overflow        busy       nibbles being computed (RUN)
module nibble_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned IdxW = (Nib > 1) ? $clog2(Nib) : 1;
  localparam int unsigned Msb  = WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [IdxW-1:0]   idx_q;

  logic [3:0]        a_nib, b_nib, fa_sum;
  logic              fa_cout;
  logic              last_nib;

  assign last_nib = (idx_q == IdxW'(Nib - 1));
  assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib    = b_q[{idx_q, 2'b00} +: 4];

  // Shared 4-bit ripple-carry adder (FA4).
  always_comb begin
    logic [4:0] c;
    c      = '0;
    fa_sum = '0;
    c[0]   = carry_q;
    for (int i = 0; i < 4; i++) begin
      fa_sum[i] = a_nib[i] ^ b_nib[i] ^ c[i];
      c[i+1]    = (a_nib[i] & b_nib[i]) | (c[i] & (a_nib[i] ^ b_nib[i]));
    end
    fa_cout = c[4];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StRun;
      StRun:   if (last_nib)  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StRun);
    out_valid = (state_q == StDone);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  // Datapath: operand capture, per-nibble accumulation, final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            // Subtraction is a + ~b + 1; the +1 enters through the carry flop.
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            idx_q   <= '0;
          end
        end
        StRun: begin
          sum_q[{idx_q, 2'b00} +: 4] <= fa_sum;
          carry_q                    <= fa_cout;
          if (last_nib) begin
            cout_q <= fa_cout;
            // fa_sum[3] is the result MSB being written on this edge.
            ovf_q  <= (a_q[Msb] == b_q[Msb]) && (fa_sum[3] != a_q[Msb]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b, sum;
  logic        sub, cin;
  logic        out_valid, out_ready;
  logic        cout, ovf, busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nibble_add_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                input logic mc, output logic [15:0] r, output logic co,
                                output logic ov);
    int ua, ub, u, sres;
    ua = int'(ma);
    ub = int'(mb);
    if (!ms) begin
      u    = ua + ub + int'(mc);
      r    = u[15:0];
      co   = u[16];
      sres = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    end else begin
      u    = ua - ub;
      r    = u[15:0];
      co   = (ua >= ub);
      sres = int'($signed(ma)) - int'($signed(mb));
    end
    ov = (sres > 32767) || (sres < -32768);
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                        input logic tc, input string name);
    logic [15:0] es;
    logic        eco, eov;
    int          n;
    model(ta, tb, ts, tc, es, eco, eov);
    @(negedge clk);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) $display("FAIL %s ready: in_ready=%b required 1", name, in_ready);
    else passed++;
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    // Scramble inputs: the op in flight must not see these.
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL %s run: busy=%b in_ready=%b required 1 0", name, busy, in_ready);
    else passed++;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 4) $display("FAIL %s latency: got %0d edges required 4", name, n);
    else passed++;
    total++;
    if (sum !== es || cout !== eco || ovf !== eov)
      $display("FAIL %s result: sum=%h cout=%b ovf=%b required %h %b %b",
               name, sum, cout, ovf, es, eco, eov);
    else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1",
               name, out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; cin = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 0 || busy !== 0 || in_ready !== 1 || sum !== 16'h0 || cout !== 0 || ovf !== 0)
      $display("FAIL reset: ov=%b busy=%b ir=%b sum=%h cout=%b ovf=%b required 0 0 1 0000 0 0",
               out_valid, busy, in_ready, sum, cout, ovf);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1 || busy !== 0 || out_valid !== 0)
      $display("FAIL reset_release: ir=%b busy=%b ov=%b required 1 0 0", in_ready, busy, out_valid);
    else passed++;
  endtask

  task automatic test_directed();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_ffff_1");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_7fff_1");
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, "add_cin");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub_5_7");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_8000_1");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_5_7_cin");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, "sub_8000_1_cin");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_hold();
    logic [15:0] es;
    logic        eco, eov;
    int          n;
    model(16'h8000, 16'h0001, 1'b1, 1'b0, es, eco, eov);
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; sub = 1'b1; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      total++;
      if (out_valid !== 1 || in_ready !== 0 || sum !== es || cout !== eco || ovf !== eov)
        $display("FAIL hold[%0d]: ov=%b ir=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                 i, out_valid, in_ready, sum, cout, ovf, es, eco, eov);
      else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1 || out_valid !== 0 || sum !== es || cout !== eco || ovf !== eov)
      $display("FAIL hold_release: ir=%b ov=%b sum=%h required 1 0 %h", in_ready, out_valid,
               sum, es);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 0 || in_ready !== 1)
      $display("FAIL hold_no_accept: busy=%b ir=%b required 0 1", busy, in_ready);
    else passed++;
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 0 || busy !== 0 || in_ready !== 1 || sum !== 16'h0 || cout !== 0 || ovf !== 0)
      $display("FAIL abort: ov=%b busy=%b ir=%b sum=%h required 0 0 1 0000",
               out_valid, busy, in_ready, sum);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL abort_quiet: active cycles=%0d required 0", seen);
    else passed++;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [15:0] qs[$];
    logic        qc[$], qo[$];
    logic [15:0] es;
    logic        eco, eov;
    int          last_acc, n;
    last_acc = -1;
    @(negedge clk);
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) begin
        total++;
        if (qs.size() == 0) $display("FAIL b2b_extra: out_valid with no op pending");
        else begin
          es = qs.pop_front(); eco = qc.pop_front(); eov = qo.pop_front();
          if (sum !== es || cout !== eco || ovf !== eov)
            $display("FAIL b2b_result: sum=%h cout=%b ovf=%b required %h %b %b",
                     sum, cout, ovf, es, eco, eov);
          else passed++;
        end
      end
      if (in_ready === 1'b1) begin
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != 6)
            $display("FAIL b2b_spacing: got %0d clocks required 6", cyc - last_acc);
          else passed++;
        end
        last_acc = cyc;
        model(a, b, sub, cin, es, eco, eov);
        qs.push_back(es); qc.push_back(eco); qo.push_back(eov);
      end else begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (qs.size() > 0 && n < 20) begin
      if (out_valid === 1'b1) begin
        total++;
        es = qs.pop_front(); eco = qc.pop_front(); eov = qo.pop_front();
        if (sum !== es || cout !== eco || ovf !== eov)
          $display("FAIL b2b_drain: sum=%h cout=%b ovf=%b required %h %b %b",
                   sum, cout, ovf, es, eco, eov);
        else passed++;
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (qs.size() != 0) $display("FAIL b2b_pending: %0d results missing required 0", qs.size());
    else passed++;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
